// File: rtl/servo_angle_ramp_if.sv
// Command handshake between the angle source and the servo ramp stage.
// The source drives cmd_valid and cmd_deg and holds them until cmd_ready is seen high.
interface servo_angle_ramp_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_deg;

  modport master (
    output cmd_valid,
    output cmd_deg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_deg,
    output cmd_ready
  );
endinterface

// File: rtl/servo_angle_ramp.sv
// Converts a commanded angle in degrees to PWM pulse ticks and slews the PWM angle
// toward it by one tick every STEP_FRAMES servo frames.
module servo_angle_ramp #(
  parameter int unsigned FRAME_CYCLES = 1_000_000,
  parameter int unsigned STEP_FRAMES  = 2,
  parameter int unsigned MIN_TICK     = 5,
  parameter int unsigned PARK_TICK    = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  servo_angle_ramp_if.slave   cmd,
  output logic [7:0]          angle,
  output logic                busy,
  output logic                done,
  output logic                frame_tick
);

  localparam int unsigned FrameW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned StepW  = $clog2(STEP_FRAMES + 1);

  typedef enum logic [1:0] {StIdle, StConvert, StRamp} state_e;

  state_e              state_q;
  logic [FrameW-1:0]   frame_cnt_q;
  logic [StepW-1:0]    step_cnt_q;
  logic [7:0]          deg_q;
  logic [7:0]          target_q;
  logic [7:0]          angle_q;
  logic                done_q;
  logic [7:0]          deg_clamped;
  logic [14:0]         scaled;

  assign frame_tick    = (frame_cnt_q == FrameW'(FRAME_CYCLES - 1));
  assign cmd.cmd_ready = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign angle         = angle_q;
  assign done          = done_q;

  assign deg_clamped = (cmd.cmd_deg > 8'd180) ? 8'd180 : cmd.cmd_deg;
  // deg*57/512 with rounding: maps 0..180 degrees onto 0..20 ticks.
  assign scaled      = {7'd0, deg_q} * 15'd57 + 15'd256;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_tick) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      deg_q      <= '0;
      target_q   <= 8'(PARK_TICK);
      angle_q    <= 8'(PARK_TICK);
      step_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd.cmd_valid) begin
            deg_q   <= deg_clamped;
            state_q <= StConvert;
          end
        end
        StConvert: begin
          target_q   <= 8'(MIN_TICK) + 8'(scaled >> 9);
          step_cnt_q <= '0;
          state_q    <= StRamp;
        end
        StRamp: begin
          if (angle_q == target_q) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (frame_tick) begin
            if (step_cnt_q == StepW'(STEP_FRAMES - 1)) begin
              step_cnt_q <= '0;
              angle_q    <= (target_q > angle_q) ? angle_q + 8'd1 : angle_q - 8'd1;
            end else begin
              step_cnt_q <= step_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
